// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one handshake multiplier between N_REQ requesters.
// Operands are latched at grant and held until the multiplier's result has been taken.
//
// state | meaning
// IDLE  | waiting for requests; combinational one-hot ready to the round-robin winner
// ISSUE | latched operands presented with mul_in_valid_o until the multiplier accepts
// WAIT  | request accepted; result taken in the same cycle mul_out_valid_i rises
// RESP  | captured result held on rsp_valid_o[id] until the owning requester accepts
module mul_share_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_a_i,
  input  logic [N_REQ*DATA_W-1:0] req_b_i,
  input  logic [N_REQ*2-1:0]      req_op_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  input  logic [N_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]       rsp_result_o,
  output logic [DATA_W-1:0]       mul_a_o,
  output logic [DATA_W-1:0]       mul_b_o,
  output logic [1:0]              mul_op_o,
  output logic                    mul_in_valid_o,
  input  logic                    mul_in_ready_i,
  input  logic                    mul_out_valid_i,
  output logic                    mul_out_ready_o,
  input  logic [DATA_W-1:0]       mul_result_i,
  output logic [15:0]             ops_done_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   res_q;
  logic [15:0]         ops_q;
  logic                in_valid_q;
  logic [N_REQ-1:0]    rsp_valid_q;

  logic [2*N_REQ-1:0]  valid_dbl;
  logic [N_REQ-1:0]    valid_rot;
  logic [ID_W:0]       win_sum;
  logic [ID_W-1:0]     winner;
  logic                win_found;
  logic [N_REQ-1:0]    grant;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [1:0]          sel_op;
  logic [ID_W-1:0]     next_ptr;

  // Rotate the valids so bit k is requester (rr_ptr + k) mod N_REQ; lowest set bit wins.
  always_comb begin
    valid_dbl = {req_valid_i, req_valid_i} >> rr_ptr;
    valid_rot = valid_dbl[N_REQ-1:0];
    win_found = 1'b0;
    win_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
      end
    end
    if (win_sum >= (ID_W+1)'(N_REQ)) win_sum = win_sum - (ID_W+1)'(N_REQ);
    winner = win_sum[ID_W-1:0];
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == winner) begin
        sel_a  = req_a_i[k*DATA_W +: DATA_W];
        sel_b  = req_b_i[k*DATA_W +: DATA_W];
        sel_op = req_op_i[k*2 +: 2];
      end
    end
  end

  assign grant    = win_found ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner) : '0;
  assign next_ptr = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

  // rst_n gating keeps ready low while reset is held even if requesters are valid.
  assign req_ready_o     = (state == IDLE && rst_n) ? grant : '0;
  assign mul_out_ready_o = (state == WAIT) && mul_out_valid_i;
  assign mul_in_valid_o  = in_valid_q;
  assign mul_a_o         = a_q;
  assign mul_b_o         = b_q;
  assign mul_op_o        = op_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_result_o    = res_q;
  assign ops_done_o      = ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      ops_q       <= '0;
      in_valid_q  <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            op_q       <= sel_op;
            id_q       <= winner;
            in_valid_q <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mul_in_ready_i) begin
            in_valid_q <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (mul_out_valid_i) begin
            res_q       <= mul_result_i;
            rsp_valid_q <= {{(N_REQ-1){1'b0}}, 1'b1} << id_q;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i[id_q]) begin
            rsp_valid_q <= '0;
            rr_ptr      <= next_ptr;
            ops_q       <= ops_q + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: requests push expected products, a negedge
// monitor pops on each response handshake; a behavioural multiplier sits on the mul port.
module tb_mul_share_arbiter;
  localparam int N = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*W-1:0] req_a_i, req_b_i;
  logic [N*2-1:0] req_op_i;
  logic [W-1:0]   rsp_result_o, mul_a_o, mul_b_o, mul_result_i;
  logic [1:0]     mul_op_o;
  logic           mul_in_valid_o, mul_in_ready_i, mul_out_valid_i, mul_out_ready_o;
  logic [15:0]    ops_done_o;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_op_o(mul_op_o),
    .mul_in_valid_o(mul_in_valid_o), .mul_in_ready_i(mul_in_ready_i),
    .mul_out_valid_i(mul_out_valid_i), .mul_out_ready_o(mul_out_ready_o),
    .mul_result_i(mul_result_i), .ops_done_o(ops_done_o)
  );

  typedef struct {
    int          id;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rsp_cnt = 0;
  int          last_id = -1;
  logic [31:0] last_res = '0;

  int   mode = 0;      // multiplier input-ready: 0 always, 1 random, 2 never
  int   lat_min = 1;
  int   lat_max = 1;
  int   in_hs_cnt = 0;
  int   in_valid_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: extend each operand per op, multiply in 64 bits, pick low or high word.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor / scoreboard state
  int          rr_ptr = 0;
  bit          outstanding = 0;
  int          ops_exp = 0;
  logic [N-1:0] prev_rv = '0;
  logic [W-1:0] prev_res = '0;
  bit          prev_acc = 0;
  bit          prev_in_hs = 0;
  logic [N-1:0] exp_rdy, hs, acc, oh;
  bit          found;
  int          idx;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      outstanding = 0;
      rr_ptr      = 0;
      ops_exp     = 0;
      prev_rv     = '0;
      prev_acc    = 0;
      prev_in_hs  = 0;
    end else begin
      chk("ops_done", 64'(ops_done_o), 64'(ops_exp));
      exp_rdy = '0;
      found   = 0;
      if (!outstanding) begin
        for (int k = 0; k < N; k++) begin
          idx = (rr_ptr + k) % N;
          if (!found && req_valid_i[idx]) begin
            found        = 1;
            exp_rdy[idx] = 1'b1;
          end
        end
      end
      chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      if (prev_rv != '0 && !prev_acc) begin
        chk("rsp_valid_stable", 64'(rsp_valid_o), 64'(prev_rv));
        chk("rsp_result_stable", 64'(rsp_result_o), 64'(prev_res));
      end
      if (prev_in_hs) chk("in_valid_drop", 64'(mul_in_valid_o), 64'(0));
      if (rsp_valid_o != '0) begin
        chk("issue_in_resp", 64'(mul_in_valid_o), 64'(0));
        if (sb.size() == 0) chk("rsp_valid_unexpected", 64'(rsp_valid_o), 64'(0));
        else begin
          oh = '0;
          oh[sb[0].id] = 1'b1;
          chk("rsp_valid_id", 64'(rsp_valid_o), 64'(oh));
        end
      end
      hs = req_valid_i & req_ready_o;
      for (int k = 0; k < N; k++) begin
        if (hs[k]) begin
          e.id  = k;
          e.res = ref_mul(req_a_i[k*W +: W], req_b_i[k*W +: W], req_op_i[k*2 +: 2]);
          sb.push_back(e);
          grant_log.push_back(k);
          outstanding = 1;
        end
      end
      acc = rsp_valid_o & rsp_ready_i;
      if (acc != '0) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'(acc), 64'(0));
        else begin
          e  = sb.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          chk("rsp_id", 64'(acc), 64'(oh));
          chk("rsp_result", 64'(rsp_result_o), 64'(e.res));
          last_id     = e.id;
          last_res    = rsp_result_o;
          ops_exp     = (ops_exp + 1) % 65536;
          rr_ptr      = (e.id + 1) % N;
          outstanding = 0;
          rsp_cnt++;
        end
      end
      prev_rv    = rsp_valid_o;
      prev_res   = rsp_result_o;
      prev_acc   = (acc != '0);
      prev_in_hs = mul_in_valid_o && mul_in_ready_i;
    end
  end

  // Behavioural multiplier: result appears lat cycles after the input handshake.
  bit          busy = 0;
  bit          in_hs, out_hs;
  int          lat = 0;
  logic [31:0] cap_a, cap_b, m_res;
  logic [1:0]  cap_op;

  initial begin
    mul_in_ready_i  = 1'b0;
    mul_out_valid_i = 1'b0;
    mul_result_i    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy            = 0;
        mul_out_valid_i = 1'b0;
        mul_in_ready_i  = 1'b0;
        mul_result_i    = '0;
      end else begin
        if (mul_in_valid_o) in_valid_cyc++;
        in_hs  = mul_in_valid_o && mul_in_ready_i;
        out_hs = mul_out_valid_i && mul_out_ready_o;
        if (busy) begin
          chk("mul_a_stable", 64'(mul_a_o), 64'(cap_a));
          chk("mul_b_stable", 64'(mul_b_o), 64'(cap_b));
          chk("mul_op_stable", 64'(mul_op_o), 64'(cap_op));
        end
        if (in_hs) begin
          busy   = 1;
          cap_a  = mul_a_o;
          cap_b  = mul_b_o;
          cap_op = mul_op_o;
          m_res  = ref_mul(cap_a, cap_b, cap_op);
          lat    = int'($urandom_range(lat_max, lat_min));
          in_hs_cnt++;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
          if (out_hs) begin
            busy            = 0;
            mul_out_valid_i = 1'b0;
          end
          if (busy && !mul_out_valid_i) begin
            lat--;
            if (lat <= 0) begin
              mul_out_valid_i = 1'b1;
              mul_result_i    = m_res;
            end
          end
          if (busy) mul_in_ready_i = 1'b0;
          else if (mode == 0) mul_in_ready_i = 1'b1;
          else if (mode == 2) mul_in_ready_i = 1'b0;
          else mul_in_ready_i = ($urandom_range(0, 1) == 1);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_a_i[i*W +: W]  = a;
    req_b_i[i*W +: W]  = b;
    req_op_i[i*2 +: 2] = op;
  endtask

  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op);
    bit got = 0;
    set_req(i, a, b, op);
    req_valid_i[i] = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = req_ready_o[i];
      @(posedge clk);
      #1;
    end
    req_valid_i[i] = 1'b0;
    chk("req_grant_timeout", 64'(got), 64'(1));
  endtask

  task automatic wait_rsp(input int target);
    for (int t = 0; t < 500 && rsp_cnt < target; t++) cycles(1);
    chk("rsp_timeout", 64'(rsp_cnt >= target), 64'(1));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctrl"}, 64'({req_ready_o, rsp_valid_o, mul_in_valid_o, mul_out_ready_o,
                            mul_op_o, ops_done_o}), 64'(0));
    chk({nm, "_data"}, {mul_a_o, mul_b_o}, 64'(0));
    chk({nm, "_result"}, 64'(rsp_result_o), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  int base, snap, snap2;

  initial begin
    req_valid_i = '0;
    rsp_ready_i = '1;
    req_a_i     = '0;
    req_b_i     = '0;
    req_op_i    = '0;
    rst_n       = 1'b0;
    cycles(3);
    check_zero("reset");
    rst_n = 1'b1;
    cycles(2);

    // single MUL, multiplier always ready
    base = rsp_cnt;
    snap = in_valid_cyc;
    do_req(0, 32'd7, 32'd6, 2'b00);
    wait_rsp(base + 1);
    chk("mul_result", 64'(last_res), 64'd42);
    chk("mul_id", 64'(last_id), 64'd0);
    chk("mul_ops_done", 64'(ops_done_o), 64'd1);
    chk("mul_in_valid_cycles", 64'(in_valid_cyc - snap), 64'd1);

    // high-word ops from requester 1
    base = rsp_cnt;
    do_req(1, 32'hFFFF_FFFF, 32'h2, 2'b01);
    wait_rsp(base + 1);
    chk("mulh_result", 64'(last_res), 64'hFFFF_FFFF);
    chk("mulh_id", 64'(last_id), 64'd1);
    do_req(1, 32'hFFFF_FFFF, 32'h2, 2'b11);
    wait_rsp(base + 2);
    chk("mulhu_result", 64'(last_res), 64'h1);
    do_req(1, 32'hFFFF_FFFF, 32'h2, 2'b10);
    wait_rsp(base + 3);
    chk("mulhsu_result", 64'(last_res), 64'hFFFF_FFFF);

    // fairness with both requesters continuously valid
    grant_log.delete();
    base = rsp_cnt;
    set_req(0, 32'd11, 32'd13, 2'b00);
    set_req(1, 32'hFFFF_FFF0, 32'd3, 2'b01);
    req_valid_i = '1;
    for (int t = 0; t < 300 && grant_log.size() < 6; t++) cycles(1);
    req_valid_i = '0;
    wait_rsp(base + 6);
    chk("fair_count", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk("fair_order", 64'(grant_log[k]), 64'(k % 2));

    // response backpressure
    base = rsp_cnt;
    rsp_ready_i = '0;
    do_req(0, 32'h1000, 32'h3, 2'b00);
    for (int t = 0; t < 100 && rsp_valid_o == '0; t++) cycles(1);
    snap = in_hs_cnt;
    set_req(1, 32'd5, 32'd5, 2'b00);
    req_valid_i[1] = 1'b1;
    rsp_ready_i[1] = 1'b1;
    cycles(10);
    chk("bp_valid", 64'(rsp_valid_o), 64'b01);
    chk("bp_result", 64'(rsp_result_o), 64'h3000);
    chk("bp_no_issue", 64'(in_hs_cnt - snap), 64'd0);
    req_valid_i[1] = 1'b0;
    rsp_ready_i = '1;
    wait_rsp(base + 1);
    chk("bp_last", 64'(last_res), 64'h3000);

    // operand stability: requester changes inputs right after grant
    base = rsp_cnt;
    mode = 2;
    do_req(0, 32'h12345, 32'h10, 2'b00);
    set_req(0, 32'hDEAD, 32'hBEEF, 2'b11);
    cycles(4);
    chk("stable_a", 64'(mul_a_o), 64'h12345);
    chk("stable_op", 64'(mul_op_o), 64'd0);
    mode = 0;
    wait_rsp(base + 1);
    chk("stable_result", 64'(last_res), 64'h123450);

    // reset while waiting on the multiplier
    lat_min = 40;
    lat_max = 40;
    snap = in_hs_cnt;
    do_req(0, 32'd9, 32'd9, 2'b00);
    for (int t = 0; t < 50 && in_hs_cnt == snap; t++) cycles(1);
    cycles(2);
    snap2 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check_zero("reset_wait");
    cycles(2);
    rst_n = 1'b1;
    lat_min = 1;
    lat_max = 1;
    cycles(1);
    chk("reset_no_rsp", 64'(rsp_cnt - snap2), 64'd0);
    base = rsp_cnt;
    do_req(0, 32'd2, 32'd3, 2'b00);
    wait_rsp(base + 1);
    chk("post_reset_result", 64'(last_res), 64'd6);
    chk("post_reset_ops", 64'(ops_done_o), 64'd1);

    // randomized traffic with random multiplier stalls and latency
    mode = 1;
    lat_min = 1;
    lat_max = 3;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, pick(), pick(), 2'($urandom_range(0, 3)));
        req_valid_i[i] = ($urandom_range(0, 2) != 0);
        rsp_ready_i[i] = ($urandom_range(0, 3) != 0);
      end
      cycles(1);
    end
    req_valid_i = '0;
    rsp_ready_i = '1;
    for (int t = 0; t < 200 && sb.size() != 0; t++) cycles(1);
    chk("drain", 64'(sb.size()), 64'd0);
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
